regfile_wr_ctrl: RTL and testbench
==================================

// Module: regfile_wr_ctrl
// PURPOSE
//  Sequences the single write port of the 32x32 register file. After reset it
//  zero-fills r1..r31 (the storage registers have no reset). It then arbitrates
//  round-robin between ALU and MEM writeback requesters, and keeps a 32-bit
//  pending scoreboard so decode can detect read-after-write hazards.
//  Sits between the pipeline writeback stage and the register file's Awr/Din/WrEn.
// PARAMETERS
//  AW  5   register address width (32 registers)
//  DW  32  data width
// PORTS
//  Clk        in  1   clock, all state on rising edge
//  Rst        in  1   synchronous, active-high reset
//  A_Valid    in  1   ALU writeback request
//  A_Addr     in  AW  ALU destination register
//  A_Data     in  DW  ALU result
//  A_Ready    out 1   ALU request accepted this cycle
//  M_Valid    in  1   MEM (load) writeback request
//  M_Addr     in  AW  MEM destination register
//  M_Data     in  DW  load data
//  M_Ready    out 1   MEM request accepted this cycle
//  Hold       in  1   pipeline stall: no grant while high
//  Rsv_En     in  1   decode reserves a destination register
//  Rsv_Addr   in  AW  register being reserved
//  Ard1/Ard2  in  AW  decode read addresses (for scoreboard lookup)
//  Busy1/Busy2 out 1  pending bit of Ard1/Ard2 (combinational)
//  Awr        out AW  to register file write address (registered)
//  Din        out DW  to register file write data (registered)
//  WrEn       out 1   to register file write enable (registered)
//  Init_Done  out 1   high once zero-fill complete
// BEHAVIOUR
//  Reset: WrEn=0, Awr=0, Din=0, Init_Done=0, A_Ready=M_Ready=0, pending=0,
//   rr pointer=ALU, FSM->INIT with sweep counter=1.
//  FSM INIT: each cycle WrEn=1, Awr=counter, Din=0; counter 1..31; after
//   writing r31 -> RUN, Init_Done=1 from that next cycle. 31 cycles. Requests
//   ignored (Ready=0), Rsv_En ignored, Busy1/2=0.
//  FSM RUN: grant when !Hold. Only one valid -> grant it. Both valid -> grant
//   side named by rr pointer; pointer flips to the other side after any grant.
//  Ready is combinational, same cycle as grant; transfer = Valid & Ready.
//  Latency: accepted request appears on Awr/Din/WrEn the next cycle, 1 cycle.
//   WrEn deasserts the cycle after a no-grant cycle.
//  Addr 0: request accepted (Ready=1) but WrEn stays 0; r0 is never written
//   after INIT.
//  Scoreboard: Rsv_En sets pending[Rsv_Addr]; an accepted write clears
//   pending[addr] on the same edge. Same register set+clear on one edge ->
//   set wins (newer producer). pending[0] always 0.
//  Busy1 = pending[Ard1], Busy2 = pending[Ard2]; Ard=0 -> 0.
//  Rst mid-INIT or mid-RUN: restart INIT, clear pending, drop in-flight write.
//  Rst takes priority over every other input.
// CONFIGURATION
//  RF_WR_BYPASS_EN defined: adds outputs Fwd1/Fwd2 (1b) and FwdData1/FwdData2
//   (DW). FwdN=1 when WrEn & Awr==ArdN & ArdN!=0; FwdDataN=Din. This lets decode
//   take a value in the same cycle it is written. BusyN is also forced to 0
//   when FwdN=1.
//  Undefined: no forward ports; a read of a register being written in the
//   current cycle sees its old value.
// TESTING
//  Rst 1 cycle -> 31 writes, Awr 1..31, Din=0, then Init_Done=1; no Ready.
//  RUN, A_Valid only, A_Addr=5, A_Data=0xDEADBEEF -> A_Ready same cycle;
//   next cycle WrEn=1, Awr=5, Din=0xDEADBEEF.
//  A and M valid 4 cycles, addr 3/7 -> grants A,M,A,M; Awr 3,7,3,7.
//   Hold=1 -> no Ready, WrEn=0 next cycle.
//  Rsv_En addr 9 -> Busy1=1 when Ard1=9. M write to 9 -> Busy1=0 after edge.
//   Rsv and write to 9 on the same edge -> stays 1.
//  A_Addr=0 accepted -> A_Ready=1, WrEn stays 0. Rsv_Addr=0 -> Busy stays 0.
//  Rst asserted mid-RUN with pending bits set -> pending cleared, INIT restarts
//   at Awr=1.

Source files
------------

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: zero-fills r1..r31 after reset, then round-robin arbitrates ALU/MEM writebacks with a RAW pending scoreboard.
// RF_WR_BYPASS_EN adds same-cycle forwarding ports Fwd1/Fwd2/FwdData1/FwdData2.
module regfile_wr_ctrl #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          A_Valid,
  input  logic [AW-1:0] A_Addr,
  input  logic [DW-1:0] A_Data,
  output logic          A_Ready,
  input  logic          M_Valid,
  input  logic [AW-1:0] M_Addr,
  input  logic [DW-1:0] M_Data,
  output logic          M_Ready,
  input  logic          Hold,
  input  logic          Rsv_En,
  input  logic [AW-1:0] Rsv_Addr,
  input  logic [AW-1:0] Ard1,
  input  logic [AW-1:0] Ard2,
  output logic          Busy1,
  output logic          Busy2,
  output logic [AW-1:0] Awr,
  output logic [DW-1:0] Din,
  output logic          WrEn,
`ifdef RF_WR_BYPASS_EN
  output logic          Fwd1,
  output logic          Fwd2,
  output logic [DW-1:0] FwdData1,
  output logic [DW-1:0] FwdData2,
`endif
  output logic          Init_Done
);
  localparam int N = 1 << AW;
  typedef enum logic {INIT, RUN} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, awr_q, awr_d, g_addr;
  logic [DW-1:0] din_q, din_d, g_data;
  logic          wren_q, wren_d, done_q, done_d, rr_q, rr_d;
  logic [N-1:0]  pend_q, pend_d;
  logic          run, a_gnt, m_gnt;
  assign run    = state_q == RUN;
  // rr_q = 0 favours ALU on a tie, 1 favours MEM
  assign a_gnt  = run & !Rst & !Hold & A_Valid & (!M_Valid | !rr_q);
  assign m_gnt  = run & !Rst & !Hold & M_Valid & (!A_Valid | rr_q);
  assign g_addr = a_gnt ? A_Addr : M_Addr;
  assign g_data = a_gnt ? A_Data : M_Data;
  assign A_Ready   = a_gnt;
  assign M_Ready   = m_gnt;
  assign Awr       = awr_q;
  assign Din       = din_q;
  assign WrEn      = wren_q;
  assign Init_Done = done_q;
`ifdef RF_WR_BYPASS_EN
  assign Fwd1     = wren_q & (awr_q == Ard1) & (Ard1 != '0);
  assign Fwd2     = wren_q & (awr_q == Ard2) & (Ard2 != '0);
  assign FwdData1 = din_q;
  assign FwdData2 = din_q;
  assign Busy1    = pend_q[Ard1] & !Fwd1;
  assign Busy2    = pend_q[Ard2] & !Fwd2;
`else
  assign Busy1 = pend_q[Ard1];
  assign Busy2 = pend_q[Ard2];
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    awr_d   = awr_q;
    din_d   = din_q;
    wren_d  = 1'b0;
    done_d  = done_q;
    rr_d    = rr_q;
    pend_d  = pend_q;
    if (!run) begin
      wren_d  = 1'b1;
      awr_d   = cnt_q;
      din_d   = '0;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == AW'(N - 1)) ? RUN : INIT;
      done_d  = cnt_q == AW'(N - 1);
    end else begin
      if (a_gnt | m_gnt) begin
        wren_d         = g_addr != '0;
        awr_d          = g_addr;
        din_d          = g_data;
        rr_d           = !m_gnt;
        pend_d[g_addr] = 1'b0;
      end
      // reservation applied after the clear so a newer producer wins
      if (Rsv_En) pend_d[Rsv_Addr] = 1'b1;
      pend_d[0] = 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= INIT;
      cnt_q   <= AW'(1);
      awr_q   <= '0;
      din_q   <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
      rr_q    <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      awr_q   <= awr_d;
      din_q   <= din_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl: directed vector table plus reset/init sequences for regfile_wr_ctrl.
module tb_regfile_wr_ctrl;
  logic        Clk = 1'b0, Rst = 1'b1;
  logic        A_Valid, M_Valid, Hold, Rsv_En;
  logic [4:0]  A_Addr, M_Addr, Rsv_Addr, Ard1, Ard2;
  logic [31:0] A_Data, M_Data;
  logic        A_Ready, M_Ready, Busy1, Busy2, WrEn, Init_Done;
  logic [4:0]  Awr;
  logic [31:0] Din;
`ifdef RF_WR_BYPASS_EN
  logic        Fwd1, Fwd2;
  logic [31:0] FwdData1, FwdData2;
`endif
  int checks = 0, errors = 0;

  regfile_wr_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Ready(A_Ready),
    .M_Valid(M_Valid), .M_Addr(M_Addr), .M_Data(M_Data), .M_Ready(M_Ready),
    .Hold(Hold), .Rsv_En(Rsv_En), .Rsv_Addr(Rsv_Addr),
    .Ard1(Ard1), .Ard2(Ard2), .Busy1(Busy1), .Busy2(Busy2),
    .Awr(Awr), .Din(Din), .WrEn(WrEn),
`ifdef RF_WR_BYPASS_EN
    .Fwd1(Fwd1), .Fwd2(Fwd2), .FwdData1(FwdData1), .FwdData2(FwdData2),
`endif
    .Init_Done(Init_Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        hold, rv;
    logic [4:0]  ra, r1, r2;
    logic        ear, emr, eb1, eb2, ewr;
    logic [4:0]  eawr;
    logic [31:0] edin;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    A_Valid = 0; A_Addr = 0; A_Data = 0;
    M_Valid = 0; M_Addr = 0; M_Data = 0;
    Hold = 0; Rsv_En = 0; Rsv_Addr = 0; Ard1 = 0; Ard2 = 0;
  endtask

  task automatic init_sweep;
    for (int i = 1; i <= 31; i++) begin
      step;
      chk("init_wren", 32'(WrEn), 1);
      chk("init_awr", 32'(Awr), 32'(i));
      chk("init_din", Din, 0);
      if (i < 31) begin
        chk("init_done_low", 32'(Init_Done), 0);
        chk("init_a_ready", 32'(A_Ready), 0);
        chk("init_m_ready", 32'(M_Ready), 0);
      end
    end
  endtask

  initial begin
    logic [31:0] d1, d2;
    d1 = 32'h1111_1111;
    d2 = 32'h2222_2222;
    //          av aa ad            mv ma md            hd rv ra r1 r2 ear emr eb1 eb2 ewr eawr edin
    vecs[0]  = '{1, 3, d1,           1, 7, d2,           0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3, d1};
    vecs[1]  = '{1, 3, d1,           1, 7, d2,           0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 7, d2};
    vecs[2]  = '{1, 3, d1,           1, 7, d2,           0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3, d1};
    vecs[3]  = '{1, 3, d1,           1, 7, d2,           0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 7, d2};
    vecs[4]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 32'hDEADBEEF};
    vecs[5]  = '{1, 3, d1,           1, 7, d2,           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 3, d1,           1, 7, d2,           0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 7, d2};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,            0, 1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0,            1, 9, 32'h12345678, 0, 0, 0, 9, 3, 0, 1, 1, 0, 1, 9, 32'h12345678};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 9, 32'hA5A5A5A5, 0, 0, 0,            0, 1, 9, 9, 0, 1, 0, 0, 0, 1, 9, 32'hA5A5A5A5};
    vecs[11] = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 9, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[12] = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 0, 0, 9, 0, 1, 0, 1, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 0,            0, 0, 0,            0, 1, 0, 0, 9, 0, 0, 0, 1, 0, 0, 0};
    vecs[14] = '{0, 0, 0,            0, 0, 0,            0, 1, 4, 0, 9, 0, 0, 0, 1, 0, 0, 0};
    vecs[15] = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 4, 9, 0, 0, 1, 1, 0, 0, 0};

    idle;
    A_Valid = 1; M_Valid = 1; Rsv_En = 1; Rsv_Addr = 9;
    Rst = 1;
    #2;
    chk("rst_a_ready", 32'(A_Ready), 0);
    step;
    Rst = 0;
    chk("rst_wren", 32'(WrEn), 0);
    chk("rst_awr", 32'(Awr), 0);
    chk("rst_din", Din, 0);
    chk("rst_done", 32'(Init_Done), 0);
    init_sweep;
    idle;
    Ard1 = 9;
    #1;
    chk("init_rsv_ignored", 32'(Busy1), 0);
    step;
    chk("done_high", 32'(Init_Done), 1);
    chk("post_init_wren", 32'(WrEn), 0);

    for (int i = 0; i < 16; i++) begin
      A_Valid = vecs[i].av; A_Addr = vecs[i].aa; A_Data = vecs[i].ad;
      M_Valid = vecs[i].mv; M_Addr = vecs[i].ma; M_Data = vecs[i].md;
      Hold = vecs[i].hold; Rsv_En = vecs[i].rv; Rsv_Addr = vecs[i].ra;
      Ard1 = vecs[i].r1; Ard2 = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(A_Ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d_m_ready", i), 32'(M_Ready), 32'(vecs[i].emr));
      chk($sformatf("v%0d_busy1", i), 32'(Busy1), 32'(vecs[i].eb1));
      chk($sformatf("v%0d_busy2", i), 32'(Busy2), 32'(vecs[i].eb2));
      step;
      chk($sformatf("v%0d_wren", i), 32'(WrEn), 32'(vecs[i].ewr));
      if (vecs[i].ewr) begin
        chk($sformatf("v%0d_awr", i), 32'(Awr), 32'(vecs[i].eawr));
        chk($sformatf("v%0d_din", i), Din, vecs[i].edin);
      end
    end

    idle;
    A_Valid = 1; A_Addr = 6; A_Data = 32'hCAFE0006;
    Rst = 1;
    #1;
    chk("midrun_rst_a_ready", 32'(A_Ready), 0);
    step;
    Rst = 0;
    idle;
    chk("midrun_rst_wren", 32'(WrEn), 0);
    chk("midrun_rst_done", 32'(Init_Done), 0);
    for (int i = 1; i <= 3; i++) begin
      step;
      chk("reinit_awr", 32'(Awr), 32'(i));
      chk("reinit_wren", 32'(WrEn), 1);
    end
    Rst = 1;
    step;
    Rst = 0;
    chk("midinit_rst_wren", 32'(WrEn), 0);
    init_sweep;
    step;
    Ard1 = 4; Ard2 = 9;
    #1;
    chk("pend_cleared1", 32'(Busy1), 0);
    chk("pend_cleared2", 32'(Busy2), 0);
    chk("redone_high", 32'(Init_Done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
